// File: rtl/barrett_pkg.sv
// Shared types and widths for the Barrett constant precompute block.
package barrett_pkg;

   localparam int BARRETT_W = 64;
   localparam int CNT_W     = 8;

   typedef enum logic [1:0] {IDLE, BITLEN, DIVIDE, DONE} mu_state_t;

   // Width needed to hold a bitlength in 0..width.
   function automatic int bitlen_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Priority encoder: bitlength of value (leading-one index + 1), 0 for a zero input.
module lead_one_detect
   import barrett_pkg::*;
#(
   parameter int WIDTH = BARRETT_W,
   parameter int BL_W  = bitlen_w(WIDTH)
) (
   input  logic [WIDTH-1:0] value,
   output logic [BL_W-1:0]  bitlen
);

   always_comb begin
      bitlen = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (value[i]) begin
            bitlen = BL_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/barrett_mu_precomp.sv
// Barrett constant precompute: bitlength k of m and mu = floor(2^(2k)/m)
// from a bit-serial restoring divider, one quotient bit per clock.
//
// state  | meaning
// IDLE   | waiting for start_i; outputs hold the last result
// BITLEN | register k, range check, load the iteration count
// DIVIDE | one restoring-divide step per cycle, down to cnt = 0
// DONE   | valid_o pulse, then back to IDLE
module barrett_mu_precomp
   import barrett_pkg::*;
#(
   parameter int WIDTH = BARRETT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] m_i,
   output logic             busy_o,
   output logic             valid_o,
   output logic             err_o,
   output logic [WIDTH-1:0] mu_o,
   output logic [WIDTH-1:0] m_bl_o
);

   localparam int BL_W = bitlen_w(WIDTH);
   localparam logic [BL_W-1:0] BL_MAX = BL_W'(WIDTH - 2);

   mu_state_t        state;
   logic [WIDTH-1:0] m_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] q_q;
   logic [CNT_W-1:0] cnt;

   logic [BL_W-1:0]  bl;
   logic [CNT_W-1:0] two_k;
   logic             dbit;
   logic             qbit;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] q_next;

   lead_one_detect #(
      .WIDTH (WIDTH),
      .BL_W  (BL_W)
   ) u_lead_one (
      .value  (m_q),
      .bitlen (bl)
   );

   // Dividend is 2^(2k): only the first iteration shifts in a one.
   always_comb begin
      two_k   = CNT_W'(m_bl_o) << 1;
      dbit    = (cnt == two_k);
      r_shift = {r_q[WIDTH-2:0], dbit};
      qbit    = (r_shift >= m_q);
      r_next  = qbit ? (r_shift - m_q) : r_shift;
      q_next  = {q_q[WIDTH-2:0], qbit};
   end

   assign busy_o  = (state == DIVIDE);
   assign valid_o = (state == DONE);

   // An out-of-range modulus still makes one DIVIDE pass with the result
   // suppressed, so the error answer always arrives two cycles after accept.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         m_q    <= '0;
         r_q    <= '0;
         q_q    <= '0;
         cnt    <= '0;
         err_o  <= 1'b0;
         mu_o   <= '0;
         m_bl_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  m_q   <= m_i;
                  r_q   <= '0;
                  q_q   <= '0;
                  err_o <= 1'b0;
                  state <= BITLEN;
               end
            end
            BITLEN: begin
               m_bl_o <= WIDTH'(bl);
               if ((bl == '0) || (bl > BL_MAX)) begin
                  err_o <= 1'b1;
                  mu_o  <= '0;
                  cnt   <= '0;
               end else begin
                  cnt <= CNT_W'(bl) << 1;
               end
               state <= DIVIDE;
            end
            DIVIDE: begin
               r_q <= r_next;
               q_q <= q_next;
               if (cnt == '0) begin
                  if (!err_o) begin
                     mu_o <= q_next;
                  end
                  state <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_barrett_mu_precomp.sv
// Bench for barrett_mu_precomp: cycle-level reference model plus directed and random requests.
module tb_barrett_mu_precomp;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         start_i = 1'b0;
   logic [W-1:0] m_i = '0;
   logic         busy_o;
   logic         valid_o;
   logic         err_o;
   logic [W-1:0] mu_o;
   logic [W-1:0] m_bl_o;

   int n_vec  = 0;
   int n_miss = 0;
   bit checking = 1'b0;

   barrett_mu_precomp #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .start_i (start_i),
      .m_i     (m_i),
      .busy_o  (busy_o),
      .valid_o (valid_o),
      .err_o   (err_o),
      .mu_o    (mu_o),
      .m_bl_o  (m_bl_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference answer from plain arithmetic on a 128-bit dividend.
   function automatic void ref_calc(input logic [W-1:0] m, output int k,
                                    output logic [W-1:0] mu, output logic err);
      logic [127:0] num;
      k = 0;
      for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
      err = (k == 0) || (k > W - 2);
      mu  = '0;
      if (!err) begin
         num = 128'd1 << (2 * k);
         mu  = W'(num / 128'(m));
      end
   endfunction

   // Model of what the outputs must show, advanced once per rising edge.
   bit           md_active = 1'b0;
   int           md_n = 0;
   int           md_lat = 0;
   int           p_k = 0;
   logic [W-1:0] p_mu = '0;
   logic         p_err = 1'b0;
   logic [W-1:0] cur_mu = '0;
   logic [W-1:0] cur_bl = '0;
   logic         cur_err = 1'b0;

   always @(posedge clk) begin
      if (rst_i) begin
         md_active = 1'b0;
         md_n      = 0;
         cur_mu    = '0;
         cur_bl    = '0;
         cur_err   = 1'b0;
      end else if (md_active) begin
         md_n++;
         if (md_n == 1) begin
            cur_bl = W'(p_k);
            if (p_err) begin
               cur_err = 1'b1;
               cur_mu  = '0;
            end
         end
         if (md_n == md_lat && !p_err) cur_mu = p_mu;
         if (md_n == md_lat + 1) md_active = 1'b0;
      end else if (start_i) begin
         ref_calc(m_i, p_k, p_mu, p_err);
         md_lat    = p_err ? 2 : 2 * p_k + 2;
         md_active = 1'b1;
         md_n      = 0;
         cur_err   = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         chk("valid", 128'(md_active && (md_n == md_lat)), 128'(valid_o));
         chk("busy", 128'(md_active && (md_n >= 1) && (md_n < md_lat)), 128'(busy_o));
         chk("mu", 128'(mu_o), 128'(cur_mu));
         chk("m_bl", 128'(m_bl_o), 128'(cur_bl));
         chk("err", 128'(err_o), 128'(cur_err));
      end
   end

   function automatic logic [W-1:0] make_m(input int k);
      logic [W-1:0] r;
      r = {$urandom, $urandom};
      if (k == 0) return '0;
      r = r & ((64'd1 << k) - 64'd1);
      r[k-1] = 1'b1;
      return r;
   endfunction

   task automatic request(input logic [W-1:0] m, input int pulse_at, input int rst_at,
                          input bit lit, input logic [W-1:0] lit_mu, input logic [W-1:0] lit_bl,
                          input logic lit_err, input int lit_lat);
      int lat;
      int budget;
      bit seen;
      budget = (rst_at > 0) ? 40 : 300;
      @(negedge clk);
      start_i = 1'b1;
      m_i     = m;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      m_i     = {$urandom, $urandom};
      lat  = 0;
      seen = 1'b0;
      while (lat < budget && !seen) begin
         @(posedge clk);
         #1;
         lat++;
         rst_i = (lat == rst_at);
         if (valid_o) begin
            seen = 1'b1;
         end else begin
            start_i = (lat == pulse_at);
            if (start_i) m_i = {$urandom, $urandom};
         end
      end
      start_i = 1'b0;
      rst_i   = 1'b0;
      if (rst_at > 0) begin
         chk("no_valid_after_reset", 128'(seen), 128'(0));
         chk("mu_after_reset", 128'(mu_o), 128'(0));
         chk("m_bl_after_reset", 128'(m_bl_o), 128'(0));
         chk("err_after_reset", 128'(err_o), 128'(0));
      end else begin
         chk("valid_seen", 128'(seen), 128'(1));
         if (lit) begin
            chk("lit_latency", 128'(lat), 128'(lit_lat));
            chk("lit_mu", 128'(mu_o), 128'(lit_mu));
            chk("lit_m_bl", 128'(m_bl_o), 128'(lit_bl));
            chk("lit_err", 128'(err_o), 128'(lit_err));
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int           k;
      int           pulse;
      int           sel;
      logic [W-1:0] mu;
      logic         err;
      logic [W-1:0] m;

      ref_calc(64'd13, k, mu, err);
      chk("model_13_mu", 128'(mu), 128'(19));
      chk("model_13_k", 128'(k), 128'(4));
      ref_calc(64'd12289, k, mu, err);
      chk("model_12289_mu", 128'(mu), 128'(21843));

      @(posedge clk);
      checking = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_valid", 128'(valid_o), 128'(0));
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_mu", 128'(mu_o), 128'(0));
      chk("rst_m_bl", 128'(m_bl_o), 128'(0));
      chk("rst_err", 128'(err_o), 128'(0));
      rst_i = 1'b0;

      request(64'd13, -1, -1, 1'b1, 64'd19, 64'd4, 1'b0, 10);
      request(64'd12289, -1, -1, 1'b1, 64'd21843, 64'd14, 1'b0, 30);
      request(64'd1, -1, -1, 1'b1, 64'd4, 64'd1, 1'b0, 4);
      request((64'd1 << 62) - 64'd1, -1, -1, 1'b1, (64'd1 << 62) + 64'd1, 64'd62, 1'b0, 126);
      request(64'd1 << 61, -1, -1, 1'b1, 64'd1 << 63, 64'd62, 1'b0, 126);
      request(64'd0, -1, -1, 1'b1, 64'd0, 64'd0, 1'b1, 2);
      request(64'd1 << 62, -1, -1, 1'b1, 64'd0, 64'd63, 1'b1, 2);
      request(64'd13, 5, -1, 1'b1, 64'd19, 64'd4, 1'b0, 10);
      request(64'd13, -1, 5, 1'b0, '0, '0, 1'b0, 0);
      request(64'd13, -1, -1, 1'b1, 64'd19, 64'd4, 1'b0, 10);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0) begin
            case ($urandom_range(0, 2))
               0:       k = 0;
               1:       k = 63;
               default: k = 64;
            endcase
         end else begin
            k = $urandom_range(1, 62);
         end
         m = make_m(k);
         pulse = -1;
         if (k >= 1 && k <= 62 && $urandom_range(0, 3) == 0) pulse = $urandom_range(1, 2 * k + 1);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         request(m, pulse, -1, 1'b0, '0, '0, 1'b0, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
